uart_rx_ly3: RTL and testbench
==============================

# uart_rx_ly3

Receiver stage directly downstream of the board's UART transmitter: it accepts the serial `line_tx` stream (8N1, LSB first, idle high) on its `line_rx` input. It synchronises the line, detects start bits, samples each bit at mid-period and delivers each received byte with a one-cycle valid strobe. Stop-bit violations are reported as framing errors. It runs at the same bit period as the transmitter (2500 clocks per bit at the default setting).

## Interface
Parameters:
- `CLK_PER_BIT`, default 2500. Clocks per bit. Minimum 8.
- `HALF_BIT`, default `CLK_PER_BIT/2` (integer division). Offset from start-edge detection to first sample.
- `DATA_BITS`, default 8. Payload bits per frame.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `line_rx`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  8  last correctly framed byte, LSB = first data bit received.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new in that cycle.
- `frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `rx_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchroniser:
  - `line_rx` passes through 2 flops.
  - Both flops reset to 1.
  - All logic uses the synchronised value `rxs`.
- `armed` flag:
  - Cleared by reset.
  - Set when `rxs`==1 in IDLE.
  - A start is accepted only while armed. A line held low through reset release, or after a break, is therefore never taken as a start.
- FSM states and transitions:
  - IDLE: `armed` and `rxs`==0 → START. Clear bit counter `cnt`.
  - START: sample at `cnt`==HALF_BIT-1.
    - Sample 0 → DATA, `cnt` cleared, `bit_idx`=0.
    - Sample 1 → glitch. Return to IDLE, no outputs.
  - DATA:
    - Sample at `cnt`==CLK_PER_BIT-1.
    - Shift the sample in right (new bit into MSB, so the LSB arrives first).
    - `bit_idx`++.
    - After bit DATA_BITS-1 → STOP.
  - STOP: sample at `cnt`==CLK_PER_BIT-1.
    - Sample 1: `rx_data`<=shift register, pulse `rx_valid`.
    - Sample 0: pulse `frame_err`, leave `rx_data` unchanged, clear `armed`.
    - In both cases → IDLE.
- `cnt`:
  - 12+ bits. Width is `$clog2(CLK_PER_BIT)`.
  - Clears on every sample and on every state change.
  - Never wraps inside a bit.
- Back-to-back frames: the next falling edge may arrive in the cycle right after the stop sample. IDLE accepts it with no dead cycle.
- `rx_valid` and `frame_err` are mutually exclusive and never high for more than one cycle.

## Timing
- t0 = first cycle in which `rxs`==0 while in IDLE and armed. This is 2 cycles after the pin edge.
- Sample k is taken in cycle t0 + HALF_BIT + k·CLK_PER_BIT:
  - k=0: start bit.
  - k=1..8: data bits.
  - k=9: stop bit.
- `rx_valid`/`frame_err` are registered. They are high in cycle t0 + HALF_BIT + 9·CLK_PER_BIT + 1.
- Pin-to-valid latency is HALF_BIT + 9·CLK_PER_BIT + 3 cycles. At the defaults this is 23753.
- `rx_busy`:
  - Rises at t0+1.
  - Falls in the same cycle that the valid/error pulse is high.
  - After a glitch, falls at t0+HALF_BIT+1.
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `rx_busy`=0, FSM=IDLE, `armed`=0.
- Reset mid-frame:
  - Immediate abort. No pulse is produced and the partial byte is discarded.
  - Reception resumes only after `rxs` has been seen high.
- Tolerance: bytes are received correctly with transmitter bit-period error up to ±3 %.

## Structure
- Package `uart_pkg`:
  - `CLK_PER_BIT_DEFAULT` = 2500.
  - `UART_DATA_BITS` = 8.
  - FSM state enum `rx_state_t` {IDLE, START, DATA, STOP}.
  - `UART_IDLE_LVL` = 1.
- Sub-module `sync_2ff`: single-bit two-flop synchroniser with a reset-value parameter, instantiated with value 1.
- Everything else lives in one module: FSM, counters, shifter and output registers.

## Test plan
Benches use CLK_PER_BIT=16, HALF_BIT=8 unless stated; one run repeats scenario 2 at 2500.
1. Reset: assert `rst` with `line_rx`=1 → all outputs 0, `rx_busy`=0; no pulse for 200 cycles after release.
2. Frame 0x48 ('H') followed immediately by 0x31 ('1'):
   - `rx_valid` pulses twice.
   - `rx_data`=0x48, then 0x31, each at the exact cycle t0+HALF_BIT+9·CLK_PER_BIT+1.
   - `frame_err` stays 0.
3. Low glitch of 4 cycles on idle line → no `rx_valid`/`frame_err`; `rx_busy` high for exactly HALF_BIT cycles.
4. Framing error: send 0x55 with the stop bit driven 0, then hold the line low for 3 bit periods → expect:
   - one `frame_err` pulse and no `rx_valid`;
   - `rx_data` keeps its previous value;
   - no new start while the line is low;
   - after the line goes high, frame 0xA5 is received correctly.
5. Reset pulse during data bit 4 → `rx_busy`=0 immediately, no pulses. With `line_rx` low at release, no start is taken until the line is high and then falls. The following 0x3C is received.
6. Baud skew: frames 0xA5 and 0x0F sent at periods 15.5 and 16.5 cycles (≈±3 %) → both received with `frame_err`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART receive path.
package uart_pkg;

  localparam int unsigned CLK_PER_BIT_DEFAULT = 2500;
  localparam int unsigned UART_DATA_BITS      = 8;
  localparam logic        UART_IDLE_LVL       = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_ly3_sync_2ff.sv
// Single-bit two-flop synchroniser with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ly3.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, strobes each byte
// or a framing error for one cycle.
module uart_rx_ly3
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int unsigned HALF_BIT    = CLK_PER_BIT / 2,
  parameter int unsigned DATA_BITS   = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d;
  logic                 armed_q, armed_d;
  logic [1:0]           primed_q;

  sync_2ff #(.RST_VAL(UART_IDLE_LVL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (line_rx),
    .q   (rxs)
  );

  // Next-state and datapath decode; every sample point clears cnt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = rx_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // The synchroniser shows its reset level for two cycles; only a real high arms.
        if (rxs == UART_IDLE_LVL && primed_q[1]) armed_d = 1'b1;
        if (armed_q && rxs != UART_IDLE_LVL) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxs != UART_IDLE_LVL) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs == UART_IDLE_LVL) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
      armed_q   <= 1'b0;
      primed_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      rx_busy   <= (state_d != IDLE);
      armed_q   <= armed_d;
      primed_q  <= {primed_q[0], 1'b1};
    end
  end

endmodule

// File: tb/tb_uart_rx_ly3.sv
// Directed bench for uart_rx_ly3 at 16 clocks/bit plus one frame at the default rate.
module tb_uart_rx_ly3;

  localparam int CPB  = 16;
  localparam int HB   = 8;
  localparam int LAT  = HB + 9 * CPB + 3;       // 155
  localparam int LAT2 = 1250 + 9 * 2500 + 3;    // 23753

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_rx = 1'b1;
  logic       line_rx2 = 1'b1;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, frame_err, rx_busy;
  logic       rx_valid2, frame_err2, rx_busy2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_rx_ly3 #(.CLK_PER_BIT(CPB), .HALF_BIT(HB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_rx   (line_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  uart_rx_ly3 dut2 (
    .clk       (clk),
    .rst       (rst),
    .line_rx   (line_rx2),
    .rx_data   (rx_data2),
    .rx_valid  (rx_valid2),
    .frame_err (frame_err2),
    .rx_busy   (rx_busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log, sampled on the falling edge.
  int         ev_cyc [64];
  logic [7:0] ev_data[64];
  logic       ev_kind[64];
  logic       ev_busy[64];
  int         ev_n = 0;
  int         ev_bad = 0;
  int         busy_total = 0;
  int         ev2_cyc [8];
  logic [7:0] ev2_data[8];
  logic       ev2_kind[8];
  int         ev2_n = 0;

  always @(negedge clk) begin
    if (rx_busy) busy_total++;
    if (rx_valid && frame_err) ev_bad++;
    if (rx_valid || frame_err) begin
      if (ev_n < 64) begin
        ev_cyc[ev_n]  = cyc;
        ev_data[ev_n] = rx_data;
        ev_kind[ev_n] = frame_err;
        ev_busy[ev_n] = rx_busy;
      end
      ev_n++;
    end
    if (rx_valid2 || frame_err2) begin
      if (ev2_n < 8) begin
        ev2_cyc[ev2_n]  = cyc;
        ev2_data[ev2_n] = rx_data2;
        ev2_kind[ev2_n] = frame_err2;
      end
      ev2_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) line_rx2 = v;
    else     line_rx  = v;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int per, input bit sel);
    drive(sel, 1'b0);
    #(per);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      #(per);
    end
    drive(sel, stop);
    #(per);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rp, bt, sc, sc1, sc2;

    // Reset values with the line idle.
    repeat (3) @(negedge clk);
    check("rst_data",  32'(rx_data),   32'h00);
    check("rst_valid", 32'(rx_valid),  32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_busy",  32'(rx_busy),   32'h0);
    @(posedge clk); #1 rst = 1'b0;
    rp = ev_n; bt = busy_total;
    repeat (200) @(posedge clk);
    #1;
    check("idle_pulses", 32'(ev_n - rp), 32'd0);
    check("idle_busy",   32'(busy_total - bt), 32'd0);

    // Back-to-back 0x48, 0x31.
    @(posedge clk); #1;
    rp = ev_n; sc1 = cyc;
    send(8'h48, 1'b1, 160, 1'b0);
    sc2 = cyc;
    send(8'h31, 1'b1, 160, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("b2b_count", 32'(ev_n - rp), 32'd2);
    check("b2b_data0", 32'(ev_data[rp]), 32'h48);
    check("b2b_cyc0",  32'(ev_cyc[rp]), 32'(sc1 + LAT));
    check("b2b_kind0", 32'(ev_kind[rp]), 32'h0);
    check("b2b_busy0", 32'(ev_busy[rp]), 32'h0);
    check("b2b_data1", 32'(ev_data[rp+1]), 32'h31);
    check("b2b_cyc1",  32'(ev_cyc[rp+1]), 32'(sc2 + LAT));
    check("b2b_kind1", 32'(ev_kind[rp+1]), 32'h0);
    check("b2b_busy1", 32'(ev_busy[rp+1]), 32'h0);

    // 4-cycle low glitch.
    @(posedge clk); #1;
    rp = ev_n; bt = busy_total;
    line_rx = 1'b0;
    #40;
    line_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_pulses", 32'(ev_n - rp), 32'd0);
    check("glitch_busy",   32'(busy_total - bt), 32'd8);

    // Framing error then a held-low line.
    @(posedge clk); #1;
    rp = ev_n; sc = cyc;
    send(8'h55, 1'b0, 160, 1'b0);
    bt = busy_total;
    #480;
    check("ferr_count", 32'(ev_n - rp), 32'd1);
    check("ferr_kind",  32'(ev_kind[rp]), 32'h1);
    check("ferr_cyc",   32'(ev_cyc[rp]), 32'(sc + LAT));
    check("ferr_hold",  32'(rx_data), 32'h31);
    check("ferr_low_busy", 32'(busy_total - bt), 32'd0);
    line_rx = 1'b1;
    #320;
    rp = ev_n; sc = cyc;
    send(8'hA5, 1'b1, 160, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("after_ferr_count", 32'(ev_n - rp), 32'd1);
    check("after_ferr_data",  32'(ev_data[rp]), 32'hA5);
    check("after_ferr_cyc",   32'(ev_cyc[rp]), 32'(sc + LAT));
    check("after_ferr_kind",  32'(ev_kind[rp]), 32'h0);

    // Reset during data bit 4 with the line held low across release.
    @(posedge clk); #1;
    rp = ev_n;
    line_rx = 1'b0;
    #(5 * 160 + 80);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(rx_busy), 32'h0);
    check("midrst_data", 32'(rx_data), 32'h00);
    @(posedge clk); #1 rst = 1'b0;
    bt = busy_total;
    #320;
    check("midrst_pulses", 32'(ev_n - rp), 32'd0);
    check("midrst_low_busy", 32'(busy_total - bt), 32'd0);
    line_rx = 1'b1;
    #160;
    rp = ev_n; sc = cyc;
    send(8'h3C, 1'b1, 160, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_rx_count", 32'(ev_n - rp), 32'd1);
    check("midrst_rx_data",  32'(ev_data[rp]), 32'h3C);
    check("midrst_rx_cyc",   32'(ev_cyc[rp]), 32'(sc + LAT));

    // Baud skew of about -3 % and +3 %.
    @(posedge clk); #1;
    rp = ev_n;
    send(8'hA5, 1'b1, 155, 1'b0);
    send(8'h0F, 1'b1, 165, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("skew_count", 32'(ev_n - rp), 32'd2);
    check("skew_data0", 32'(ev_data[rp]), 32'hA5);
    check("skew_kind0", 32'(ev_kind[rp]), 32'h0);
    check("skew_data1", 32'(ev_data[rp+1]), 32'h0F);
    check("skew_kind1", 32'(ev_kind[rp+1]), 32'h0);
    check("both_pulses", 32'(ev_bad), 32'd0);

    // One frame at the default 2500 clocks per bit.
    @(posedge clk); #1;
    sc = cyc;
    check("dflt_quiet", 32'(ev2_n), 32'd0);
    send(8'h48, 1'b1, 25000, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    check("dflt_count", 32'(ev2_n), 32'd1);
    check("dflt_data",  32'(ev2_data[0]), 32'h48);
    check("dflt_cyc",   32'(ev2_cyc[0]), 32'(sc + LAT2));
    check("dflt_kind",  32'(ev2_kind[0]), 32'h0);
    check("dflt_busy",  32'(rx_busy2), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
